// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: controller states and the
// operation selected by the {Q0, Q(-1)} bit pair.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // 11 is a second "do nothing" pair; it gets its own name so every code is legal
   typedef enum logic [1:0] {
      NOP    = 2'b00,
      ADD    = 2'b01,
      SUB    = 2'b10,
      NOP_HI = 2'b11
   } booth_op_e;

   function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
      return booth_op_e'({q0, qm1});
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/subtract of the multiplicand
// into the accumulator, then arithmetic right shift of {acc, Q, Q(-1)}.
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned N = 9
) (
   input  logic [N-1:0] acc_i,
   input  logic [N-1:0] q_i,
   input  logic         qm1_i,
   input  logic [N-1:0] a_i,
   output logic [N-1:0] acc_o,
   output logic [N-1:0] q_o,
   output logic         qm1_o
);

   logic [N:0] acc_x;
   logic [N:0] a_x;
   logic [N:0] sum;

   // One guard bit keeps the add/sub exact; the shift then drops it back to N bits
   always_comb begin
      acc_x = {acc_i[N-1], acc_i};
      a_x   = {a_i[N-1], a_i};
      case (booth_decode(q_i[0], qm1_i))
         ADD:     sum = acc_x + a_x;
         SUB:     sum = acc_x - a_x;
         default: sum = acc_x;
      endcase
      acc_o = sum[N:1];
      q_o   = {sum[0], q_i[N-1:1]};
      qm1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands, fixed
// latency of WIDTH+1 clocks from accepted start to the done pulse.
module booth_mult_param
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int unsigned N  = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LOAD = CW'(N);

   state_e             state_q, state_d;
   logic [N-1:0]       acc_q, acc_d;
   logic [N-1:0]       q_q, q_d;
   logic [N-1:0]       a_q, a_d;
   logic               qm1_q, qm1_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [N-1:0]       acc_n;
   logic [N-1:0]       q_n;
   logic               qm1_n;

   // One extra bit lets unsigned operands run through the signed Booth recoding
   function automatic logic [N-1:0] extend(input logic [WIDTH-1:0] v, input logic sm);
      return {sm & v[WIDTH-1], v};
   endfunction

   booth_step #(.N(N)) u_step (
      .acc_i (acc_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .a_i   (a_q),
      .acc_o (acc_n),
      .q_o   (q_n),
      .qm1_o (qm1_n)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      a_d     = a_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = extend(multiplicand, signed_mode);
               q_d     = extend(multiplier, signed_mode);
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = CNT_LOAD;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = acc_n;
            q_d   = q_n;
            qm1_d = qm1_n;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               prod_d  = {acc_n[WIDTH-2:0], q_n};
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         a_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         a_q     <= a_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign product = prod_q;
   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param at WIDTH=4 and WIDTH=8 against an integer
// arithmetic reference model.
module tb_booth_mult_param;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       sm;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       sel;
   logic       start4, start8;
   logic [7:0] p4;
   logic [15:0] p8;
   logic       b4, b8, d4, d8;
   logic [15:0] prod_s;
   logic       busy_s, done_s;

   assign start4 = start & ~sel;
   assign start8 = start & sel;
   assign prod_s = sel ? p8 : {8'h00, p4};
   assign busy_s = sel ? b8 : b4;
   assign done_s = sel ? d8 : d4;

   booth_mult_param #(.WIDTH(4)) dut4 (
      .clock(clk), .reset(rst_n), .start(start4), .signed_mode(sm),
      .multiplicand(a_in[3:0]), .multiplier(b_in[3:0]),
      .product(p4), .busy(b4), .done(d4)
   );

   booth_mult_param #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst_n), .start(start8), .signed_mode(sm),
      .multiplicand(a_in), .multiplier(b_in),
      .product(p8), .busy(b8), .done(d8)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] exp_p;
   logic [15:0] last_p;
   int unsigned acc_cyc;
   int unsigned nn;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_prod(input int w, input logic s,
                                            input logic [7:0] a, input logic [7:0] b);
      longint ma, mb, mask;
      mask = (longint'(1) << w) - 1;
      ma = longint'(a) & mask;
      mb = longint'(b) & mask;
      if (s) begin
         if (ma >= (longint'(1) << (w - 1))) ma -= (longint'(1) << w);
         if (mb >= (longint'(1) << (w - 1))) mb -= (longint'(1) << w);
      end
      return 16'((ma * mb) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Called at a negedge: the following posedge accepts the operation
   task automatic go(input logic w8, input logic s, input logic [7:0] a, input logic [7:0] b);
      sel     = w8;
      sm      = s;
      a_in    = a;
      b_in    = b;
      start   = 1'b1;
      exp_p   = ref_prod(w8 ? 8 : 4, s, a, b);
      acc_cyc = cyc + 1;
      nn      = (w8 ? 8 : 4) + 1;
      last_p  = w8 ? p8 : {8'h00, p4};
   endtask

   // mode 0: quiet inputs, 1: random inputs and start during RUN, 2: start held high
   task automatic wait_done(input int mode, input bit chain, input logic cs,
                            input logic [7:0] ca, input logic [7:0] cb);
      bit seen = 0;
      bit unstable = 0;
      for (int i = 0; i < int'(nn) + 4 && !seen; i++) begin
         @(posedge clk); @(negedge clk);
         if (done_s) begin
            seen = 1;
         end else begin
            if (!busy_s || prod_s !== last_p) unstable = 1;
            if (mode != 0) begin
               a_in  = 8'($urandom);
               b_in  = 8'($urandom);
               sm    = 1'($urandom);
               start = (mode == 2) ? 1'b1 : 1'($urandom);
            end else begin
               start = 1'b0;
            end
         end
      end
      check("latency", cyc - acc_cyc, nn);
      check("product", prod_s, exp_p);
      check("run_stable", unstable, 0);
      if (chain) go(sel, cs, ca, cb);
      else start = 1'b0;
      @(posedge clk); @(negedge clk);
      check("done_pulse", done_s, 0);
      check("busy_after", busy_s, chain);
   endtask

   typedef struct {
      logic        w8;
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] e;
   } vec_t;

   vec_t vt [7] = '{
      '{1'b0, 1'b1, 8'h03, 8'h02, 16'h0006},
      '{1'b0, 1'b1, 8'h07, 8'h07, 16'h0031},
      '{1'b0, 1'b1, 8'h08, 8'h08, 16'h0040},
      '{1'b0, 1'b1, 8'h08, 8'h07, 16'h00C8},
      '{1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1},
      '{1'b1, 1'b1, 8'h80, 8'h80, 16'h4000},
      '{1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01}
   };

   initial begin
      int ndone;
      logic [7:0] a2, b2;
      rst_n = 1'b0; start = 1'b0; sm = 1'b0; a_in = '0; b_in = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_p4", p4, 0);
      check("rst_p8", p8, 0);
      check("rst_busy4", b4, 0);
      check("rst_busy8", b8, 0);
      check("rst_done4", d4, 0);
      check("rst_done8", d8, 0);

      foreach (vt[i]) begin
         go(vt[i].w8, vt[i].s, vt[i].a, vt[i].b);
         wait_done(0, 0, 1'b0, 8'h00, 8'h00);
         check("directed", prod_s, vt[i].e);
      end

      // Start held through RUN with operands scrambled, then back-to-back issue
      go(1'b1, 1'b1, 8'hF3, 8'h25);
      a2 = 8'($urandom); b2 = 8'($urandom);
      wait_done(2, 1, 1'b0, a2, b2);
      wait_done(0, 0, 1'b0, 8'h00, 8'h00);
      check("b2b_result", prod_s, ref_prod(8, 1'b0, a2, b2));

      go(1'b0, 1'b0, 8'h0C, 8'h0B);
      wait_done(2, 1, 1'b1, 8'h09, 8'h05);
      wait_done(0, 0, 1'b0, 8'h00, 8'h00);

      for (int k = 0; k < 60; k++) begin
         go(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
         wait_done(1, 0, 1'b0, 8'h00, 8'h00);
      end

      // Abort two cycles into RUN
      go(1'b1, 1'b1, 8'h55, 8'h33);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", busy_s, 0);
      check("abort_prod8", p8, 0);
      check("abort_prod4", p4, 0);
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); @(negedge clk);
         if (d8 || d4 || b8) ndone++;
      end
      check("abort_no_done", ndone, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands, 0 means unsigned operands.
REQ-006 The block SHALL have port multiplicand, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port multiplier, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port product, output, 2*WIDTH bits: registered result of A*B.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when product is updated.

Function
REQ-011 The block SHALL use an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL capture the operands and signed_mode, clear the accumulator and Q(-1), load the counter with N=WIDTH+1, and enter RUN.
REQ-013 Operand capture SHALL sign-extend to N bits when signed_mode=1 and zero-extend when signed_mode=0.
REQ-014 In RUN, each edge SHALL perform one radix-2 Booth step: for pair {Q0,Q(-1)}, 01 adds A, 10 subtracts A, 00/11 does nothing; then arithmetic right shift of {acc,Q,Q(-1)}; then decrement the counter.
REQ-015 The step that decrements the counter to 0 SHALL write bits [2*WIDTH-1:0] of {acc,Q} to product, set done, and enter DONE.
REQ-016 Latency SHALL be fixed at N edges: start accepted at edge k gives done=1 and a valid product in the cycle after edge k+N, independent of operand values and mode.
REQ-017 done SHALL be high for exactly one cycle; DONE SHALL return to IDLE at the next edge unless start=1, in which case a new operation starts (back-to-back).
REQ-018 busy SHALL be 1 in RUN only.
REQ-019 product SHALL hold its value until the next completion; it SHALL NOT change during RUN.
REQ-020 start asserted while in RUN SHALL be ignored, with no queueing.
REQ-021 Operand and signed_mode changes after capture SHALL NOT affect the result in progress.
REQ-022 Results SHALL be exact for all operand pairs, including signed -2^(W-1) * -2^(W-1) and unsigned (2^W-1)^2.

Reset
REQ-023 reset=0 at an edge SHALL force IDLE and clear product, busy, done, the counter, the accumulator and Q(-1), with priority over start.
REQ-024 Reset during RUN SHALL abort the operation; no done pulse SHALL follow, and product SHALL read 0.

Structure
REQ-025 Package booth_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the Booth pair encodings (NOP, ADD, SUB).
REQ-026 One combinational sub-module, booth_step, SHALL implement a single add/sub plus arithmetic shift, parametrised by N; the FSM, counter and registers stay in booth_mult_param.
REQ-027 Counter width SHALL be $clog2(WIDTH+2).

Verification
REQ-028 WIDTH=4, signed, A=3, B=2, start pulse -> done exactly 5 edges later, product=8'h06.
REQ-029 WIDTH=4, signed: 7*7 gives 8'h31; -8*-8 gives 8'h40; -8*7 gives 8'hC8. WIDTH=4, unsigned: 15*15 gives 8'hE1.
REQ-030 WIDTH=8, signed, -128*-128 -> 16'h4000; unsigned 255*255 -> 16'hFE01; latency 9 edges.
REQ-031 Reset (reset=0) 2 cycles into RUN -> busy=0, product=0, and no done pulse within 20 cycles.
REQ-032 start held high through RUN with operands changed mid-run -> original result is reported, and a second operation starts in the DONE cycle and completes N edges later.
